// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state encoding and default operand width for seq_mult
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier, unsigned or two's-complement, valid/ready handshakes
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; a, b, mode sampled on transfer
//   a, b                 WIDTH-bit multiplicand / multiplier
//   mode                 0 = unsigned, 1 = signed
//   out_valid / out_ready product handshake; product held while out_valid waits
//   product              full 2*WIDTH-bit result
//   busy                 high whenever the FSM is not IDLE
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    mcand;
    logic [2*WIDTH:0]    acc;
    logic                neg;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH-1:0]  mag_nxt;

    // The most negative value negates to itself in WIDTH bits, which read
    // as unsigned is exactly its magnitude, so no extra bit is needed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    // acc holds {partial sum, remaining multiplier bits}; one add-then-shift per step.
    always_comb begin
        sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
        mag_nxt = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            product   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand    <= mag(a, mode);
                    acc      <= {{(WIDTH+1){1'b0}}, mag(b, mode)};
                    neg      <= mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt      <= CW'(WIDTH);
                    state    <= CALC;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                CALC: begin
                    acc <= {1'b0, mag_nxt};
                    cnt <= cnt - 1'b1;
                    // The last step's result goes straight to product, sign applied.
                    if (cnt == CW'(1)) begin
                        product   <= neg ? -mag_nxt : mag_nxt;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed checks of seq_mult at WIDTH=4 plus model-checked WIDTH=8 operations
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [3:0]  a = '0, b = '0;
    logic        in_ready, out_valid, busy;
    logic [7:0]  product;
    logic        in_valid8 = 1'b0, mode8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] product8;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge with the block idle; returns at a negedge, idle again.
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic m,
                       input logic [7:0] exp, input string tag);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a = x; b = y; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " product"}, 32'(product), 32'(exp));
        @(negedge clk);
        check({tag, " drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic m);
        int lat;
        logic [15:0] exp;
        exp = m ? 16'($signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y}))
                : {8'b0, x} * {8'b0, y};
        a8 = x; b8 = y; mode8 = m; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("w8 latency", 32'(lat), 32'd9);
        if (product8 !== exp)
            $display("w8 operands a=%0h b=%0h mode=%0b", x, y, m);
        check("w8 product", 32'(product8), 32'(exp));
        @(negedge clk);
    endtask

    logic [3:0] va [3] = '{4'd3, 4'h8, 4'd7};
    logic [3:0] vb [3] = '{4'd5, 4'hF, 4'hD};
    logic       vm [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ve [3] = '{8'd15, 8'h08, 8'hEB};

    initial begin
        logic [7:0] q[$];
        int idx, last, nacc;
        logic adv;

        repeat (2) @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst product", 32'(product), 32'd0);

        rst_n = 1'b1;
        op4(4'd2, 4'd3, 1'b0, 8'd6, "u2x3");
        op4(4'd15, 4'd15, 1'b0, 8'd225, "u15x15");
        op4(4'h8, 4'h8, 1'b1, 8'd64, "sm8xm8");
        op4(4'h8, 4'd7, 1'b1, 8'hC8, "sm8x7");
        op4(4'd0, 4'hF, 1'b1, 8'd0, "s0xm1");
        op4(4'd3, 4'hE, 1'b1, 8'hFA, "s3xm2");

        // Backpressure with stray in_valid during DONE
        a = 4'd6; b = 4'd7; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp valid rise", 32'(out_valid), 32'd1);
        a = 4'd1; b = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold product", 32'(product), 32'd42);
        end
        check("bp in_ready", 32'(in_ready), 32'd0);
        check("bp busy", 32'(busy), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp handoff", 32'(out_valid), 32'd0);
        check("bp idle", 32'(in_ready), 32'd1);

        // Continuous in_valid: accepts only from IDLE, every 6 cycles
        idx = 0; last = -1; nacc = 0; adv = 1'b0;
        a = va[0]; b = vb[0]; mode = vm[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (adv) begin
                idx = (idx + 1) % 3;
                a = va[idx]; b = vb[idx]; mode = vm[idx];
                adv = 1'b0;
            end
            if (out_valid)
                check("cont product", 32'(product), q.size() > 0 ? 32'(q.pop_front()) : 32'hDEAD);
            if (in_ready) begin
                q.push_back(ve[idx]);
                if (last >= 0) check("cont interval", 32'(c - last), 32'd6);
                last = c;
                nacc++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("cont accepts", 32'(nacc), 32'd4);
        check("cont drained", 32'(q.size()), 32'd0);

        // Reset during CALC aborts the operation
        a = 4'd9; b = 4'd9; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort product", 32'(product), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort out_valid", 32'(out_valid), 32'd0);
            check("abort hold ready", 32'(in_ready), 32'd1);
        end
        rst_n = 1'b1;
        op4(4'd4, 4'd5, 1'b0, 8'd20, "post_rst");

        // WIDTH=8 corners and random operands in both modes
        op8(8'h80, 8'h80, 1'b1);
        op8(8'h80, 8'h7F, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h00, 8'h80, 1'b1);
        for (int i = 0; i < 300; i++)
            op8(8'($urandom), 8'($urandom), i[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
